zx_host_link: RTL and testbench
===============================

ZX_HOST_LINK -- requirements
Module: zx_host_link

Purpose: serial slave between the HIDman MCU and the ZX bus peripheral registers. It converts MCU frames into the DI bus plus rising-edge write strobes MX, MY, MKEY and JOY.

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for sck, mosi and cs_n.
REQ-002 Parameter STROBE_SETUP, default 2, sets the clk cycles that di is stable before a strobe rises.
REQ-003 Parameter STROBE_WIDTH, default 4, sets the clk cycles a strobe stays high.
REQ-004 clk, input, 1: system clock, at least 8x the sck frequency.
REQ-005 rst_in, input, 1: reset, asynchronous, active-low.
REQ-006 sck, input, 1: serial clock from the MCU, asynchronous to clk.
REQ-007 mosi, input, 1: serial data, MSB first, sampled on the sck rising edge.
REQ-008 cs_n, input, 1: frame select, active low.
REQ-009 di, output, 8: register write data to the peripheral stage.
REQ-010 mx, my, mkey, joy, output, 1 each: write strobes, active high, consumed on their rising edge.
REQ-011 busy, output, 1: high while a strobe sequence is running or the pending slot is full.
REQ-012 overrun, output, 1: sticky flag, a frame was dropped.
REQ-013 frame_err, output, 1: sticky flag, a frame had a bad length or bad parity.

Function
REQ-014 All three serial inputs shall pass through SYNC_STAGES flip-flops; sck edges shall be detected on the synchronized signal only.
REQ-015 A frame shall consist of: cs_n falling, addr[7:0], data[7:0], cs_n rising.
REQ-016 A frame shall be valid only if exactly 16 bits are received (17 bits with the parity option of REQ-033).
REQ-017 The bit counter shall saturate at 31, and any other count at cs_n rising shall set frame_err and discard the frame.
REQ-018 Address decode: 0x01 selects mx, 0x02 selects my, 0x03 selects mkey, 0x04 selects joy; any other valid address shall be silently discarded.
REQ-019 The strobe FSM shall use states IDLE, SETUP and STROBE.
REQ-020 IDLE to SETUP: on a decoded frame, di shall load the data byte in the same cycle.
REQ-021 SETUP to STROBE: after STROBE_SETUP cycles, the selected strobe shall go high.
REQ-022 STROBE to IDLE: after STROBE_WIDTH cycles, the strobe shall go low, and it shall stay low for at least one full cycle.
REQ-023 di shall hold its value after STROBE until the next load.
REQ-024 At most one strobe shall be high at any time.
REQ-025 Latency from the synchronized cs_n rise to the strobe rise shall be 1 + STROBE_SETUP clk cycles.
REQ-026 A frame that completes while the FSM is not in IDLE shall go into a one-deep pending slot, and the FSM shall take it from the slot on its next entry to IDLE.
REQ-027 A frame that completes while the pending slot is full shall be dropped (the newest frame is lost) and shall set overrun.
REQ-028 If a frame completes in the same cycle that the pending slot drains, the new frame shall occupy the freed slot with no overrun.
REQ-029 cs_n rising with zero bits shall be ignored and shall set no flags.
REQ-030 overrun and frame_err shall clear only on reset.

Reset
REQ-031 Asserting rst_in shall immediately force: di=0xFF, all strobes=0, busy=0, overrun=0, frame_err=0, FSM=IDLE, pending slot empty, bit counter=0, synchronizers=idle (cs_n=1).
REQ-032 Reset asserted mid-frame or mid-strobe shall abort with no strobe glitch, and the first frame after release shall be processed normally.

Configuration
REQ-033 When HZX_LINK_PARITY_EN is defined, a frame shall be 17 bits with an odd parity bit last, and a parity mismatch shall set frame_err and discard the frame.
REQ-034 When HZX_LINK_PARITY_EN is undefined, a frame shall be 16 bits, no parity logic shall exist, and frame_err shall flag length errors only.

Structure
REQ-035 The shared package hzx_pkg shall hold the address constants (ADDR_MX, ADDR_MY, ADDR_MKEY, ADDR_JOY) and the FSM state enum.
REQ-036 One sub-module, hzx_link_rx, shall contain the synchronizers, shifter, bit counter and the length/parity check, and shall output a one-cycle frame_valid with addr and data.
REQ-037 The pending slot and strobe FSM shall live in the top module.

Verification
REQ-038 Frame 0x01,0x85: di=0x85 at cycle 1, mx rises at cycle 3, mx falls at cycle 7, and no other strobe toggles.
REQ-039 Frames 0x02,0x10 then 0x03,0xFE back-to-back (second completes during STROBE): my pulses, then mkey pulses after one low cycle, di=0xFE during the mkey pulse, overrun=0.
REQ-040 Three frames completing inside a single strobe sequence: first and second frames strobed, third dropped, overrun=1.
REQ-041 A 12-bit frame, then frame 0x04,0x1F: first gives frame_err=1 with no strobe; second gives a joy pulse with di=0x1F.
REQ-042 Address 0x07: no strobe, no flags, di unchanged.
REQ-043 Reset asserted during STROBE: strobe low immediately, di=0xFF; next frame 0x01,0x40 processed normally; with HZX_LINK_PARITY_EN, a bad-parity frame gives frame_err=1 and no strobe.

Source files
------------

// File: rtl/hzx_pkg.sv
// hzx_pkg: shared definitions for the HIDman-to-ZX serial link.
//   - Register address constants for the four peripheral write strobes.
//   - Frame length (16 bits, or 17 when HZX_LINK_PARITY_EN adds an odd parity bit).
//   - Strobe FSM state enum.
//   - addr_to_sel(): one-hot strobe select {joy, mkey, my, mx}, or 0 for an unmapped address.
// Configuration macro: HZX_LINK_PARITY_EN (optional odd parity bit at the end of each frame).
package hzx_pkg;

  localparam logic [7:0] ADDR_MX   = 8'h01;
  localparam logic [7:0] ADDR_MY   = 8'h02;
  localparam logic [7:0] ADDR_MKEY = 8'h03;
  localparam logic [7:0] ADDR_JOY  = 8'h04;

`ifdef HZX_LINK_PARITY_EN
  localparam int FRAME_BITS = 17;
`else
  localparam int FRAME_BITS = 16;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } strobe_state_t;

  function automatic logic [3:0] addr_to_sel(input logic [7:0] addr);
    logic [3:0] sel;
    sel = 4'b0000;
    case (addr)
      ADDR_MX:   sel = 4'b0001;
      ADDR_MY:   sel = 4'b0010;
      ADDR_MKEY: sel = 4'b0100;
      ADDR_JOY:  sel = 4'b1000;
      default:   sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/hzx_link_rx.sv
// hzx_link_rx: serial frame receiver for zx_host_link.
// Synchronizes sck/mosi/cs_n into clk, shifts mosi MSB first on each synchronized
// sck rising edge while cs_n is low, and judges the frame when cs_n rises.
// Ports:
//   clk, rst_in      system clock, asynchronous active-low reset
//   sck, mosi, cs_n  raw serial inputs from the MCU (asynchronous to clk)
//   frame_valid      one-cycle pulse: a frame of correct length (and parity) ended
//   frame_bad        one-cycle pulse: a non-empty frame had bad length or parity
//   addr, data       frame contents, meaningful while frame_valid is high
// Configuration macro: HZX_LINK_PARITY_EN (17-bit frames with trailing odd parity bit).
module hzx_link_rx
  import hzx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       frame_valid,
  output logic       frame_bad,
  output logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] cs_n_sync_reg;
  logic                   sck_prev_reg;
  logic                   cs_n_prev_reg;
  logic [4:0]             bit_cnt_reg;
  logic [FRAME_BITS-1:0]  shift_reg;

  logic sck_s, mosi_s, cs_n_s;
  logic sck_rise, cs_n_rise;
  logic len_ok, frame_ok;

  assign sck_s     = sck_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_reg[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_reg;
  assign cs_n_rise = cs_n_s & ~cs_n_prev_reg;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      sck_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      cs_n_sync_reg <= '1;
      sck_prev_reg  <= 1'b0;
      cs_n_prev_reg <= 1'b1;
      bit_cnt_reg   <= 5'd0;
      shift_reg     <= '0;
    end else begin
      // The width cast drops the oldest stage, shifting the new sample in at bit 0.
      sck_sync_reg  <= SYNC_STAGES'({sck_sync_reg, sck});
      mosi_sync_reg <= SYNC_STAGES'({mosi_sync_reg, mosi});
      cs_n_sync_reg <= SYNC_STAGES'({cs_n_sync_reg, cs_n});
      sck_prev_reg  <= sck_s;
      cs_n_prev_reg <= cs_n_s;
      // Counter is held at zero whenever the frame is deselected; the cs_n rise
      // cycle still sees the final count because the clear lands one edge later.
      if (cs_n_s) begin
        bit_cnt_reg <= 5'd0;
      end else if (sck_rise) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
        if (bit_cnt_reg != 5'd31) begin
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
        end
      end
    end
  end

  assign len_ok = (bit_cnt_reg == FRAME_LEN);

`ifdef HZX_LINK_PARITY_EN
  // Odd parity: addr, data and the parity bit together hold an odd number of ones.
  assign frame_ok = len_ok & (^shift_reg);
`else
  assign frame_ok = len_ok;
`endif

  // A select pulse with no clocks at all is not a frame and is ignored outright.
  assign frame_valid = cs_n_rise & frame_ok;
  assign frame_bad   = cs_n_rise & (bit_cnt_reg != 5'd0) & ~frame_ok;
  assign addr        = shift_reg[FRAME_BITS-1 -: 8];
  assign data        = shift_reg[FRAME_BITS-9 -: 8];

endmodule

// File: rtl/zx_host_link.sv
// zx_host_link: serial slave turning HIDman MCU frames into ZX peripheral writes.
// A decoded frame loads di, waits STROBE_SETUP cycles, then raises one of the
// write strobes for STROBE_WIDTH cycles. A frame arriving while a sequence runs is
// parked in a one-deep slot; a frame arriving with the slot full is dropped.
// Ports:
//   clk, rst_in            system clock, asynchronous active-low reset
//   sck, mosi, cs_n        serial link from the MCU
//   di[7:0]                register write data (0xFF after reset)
//   mx, my, mkey, joy      active-high write strobes (used on their rising edge)
//   busy                   strobe sequence running or pending slot occupied
//   overrun                sticky: a frame was dropped because the slot was full
//   frame_err              sticky: a frame had a bad length (or parity)
// Configuration macro: HZX_LINK_PARITY_EN (17-bit frames with odd parity bit).
module zx_host_link
  import hzx_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STROBE_SETUP = 2,
  parameter int STROBE_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic [7:0] di,
  output logic       mx,
  output logic       my,
  output logic       mkey,
  output logic       joy,
  output logic       busy,
  output logic       overrun,
  output logic       frame_err
);

  logic       rx_valid;
  logic       rx_bad;
  logic [7:0] rx_addr;
  logic [7:0] rx_data;
  logic [3:0] rx_sel;
  logic       new_frame;

  hzx_link_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst_in     (rst_in),
    .sck        (sck),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .frame_valid(rx_valid),
    .frame_bad  (rx_bad),
    .addr       (rx_addr),
    .data       (rx_data)
  );

  // Unmapped addresses never reach the FSM or the slot.
  assign rx_sel    = addr_to_sel(rx_addr);
  assign new_frame = rx_valid & (rx_sel != 4'b0000);

  strobe_state_t state_reg, state_next;
  logic [15:0]   cnt_reg, cnt_next;
  logic [7:0]    di_reg, di_next;
  logic [3:0]    sel_reg, sel_next;
  logic [3:0]    strobe_reg, strobe_next;
  logic          pend_valid_reg, pend_valid_next;
  logic [3:0]    pend_sel_reg, pend_sel_next;
  logic [7:0]    pend_data_reg, pend_data_next;
  logic          overrun_reg, overrun_next;
  logic          frame_err_reg, frame_err_next;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= IDLE;
      cnt_reg        <= 16'd0;
      di_reg         <= 8'hFF;
      sel_reg        <= 4'b0000;
      strobe_reg     <= 4'b0000;
      pend_valid_reg <= 1'b0;
      pend_sel_reg   <= 4'b0000;
      pend_data_reg  <= 8'h00;
      overrun_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      di_reg         <= di_next;
      sel_reg        <= sel_next;
      strobe_reg     <= strobe_next;
      pend_valid_reg <= pend_valid_next;
      pend_sel_reg   <= pend_sel_next;
      pend_data_reg  <= pend_data_next;
      overrun_reg    <= overrun_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    di_next         = di_reg;
    sel_next        = sel_reg;
    strobe_next     = strobe_reg;
    pend_valid_next = pend_valid_reg;
    pend_sel_next   = pend_sel_reg;
    pend_data_next  = pend_data_reg;
    overrun_next    = overrun_reg;
    frame_err_next  = frame_err_reg | rx_bad;

    case (state_reg)
      IDLE: begin
        cnt_next    = 16'd0;
        strobe_next = 4'b0000;
        if (pend_valid_reg) begin
          // Drain the slot; a frame landing in this same cycle refills it.
          state_next      = SETUP;
          di_next         = pend_data_reg;
          sel_next        = pend_sel_reg;
          pend_valid_next = new_frame;
          if (new_frame) begin
            pend_sel_next  = rx_sel;
            pend_data_next = rx_data;
          end
        end else if (new_frame) begin
          state_next = SETUP;
          di_next    = rx_data;
          sel_next   = rx_sel;
        end
      end
      SETUP: begin
        if (cnt_reg == 16'(STROBE_SETUP - 1)) begin
          state_next  = STROBE;
          cnt_next    = 16'd0;
          strobe_next = sel_reg;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 16'(STROBE_WIDTH - 1)) begin
          // Passing through IDLE guarantees at least one low cycle between strobes.
          state_next  = IDLE;
          cnt_next    = 16'd0;
          strobe_next = 4'b0000;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next  = IDLE;
        cnt_next    = 16'd0;
        strobe_next = 4'b0000;
      end
    endcase

    // Frames arriving mid-sequence park in the slot, or are lost if it is full.
    if (new_frame && (state_reg != IDLE)) begin
      if (pend_valid_reg) begin
        overrun_next = 1'b1;
      end else begin
        pend_valid_next = 1'b1;
        pend_sel_next   = rx_sel;
        pend_data_next  = rx_data;
      end
    end
  end

  assign di        = di_reg;
  assign mx        = strobe_reg[0];
  assign my        = strobe_reg[1];
  assign mkey      = strobe_reg[2];
  assign joy       = strobe_reg[3];
  assign busy      = (state_reg != IDLE) | pend_valid_reg;
  assign overrun   = overrun_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_zx_host_link.sv
// tb_zx_host_link: self-checking bench for zx_host_link.
// Two instances share the serial stimulus: u_dut uses the default timing, u_long
// uses a very long strobe so several frames can complete inside one sequence.
// A monitor logs every strobe pulse (which strobe, di at the rise, rise/fall cycle);
// each test compares that log and the flags against expectations derived from the
// frame rules. Configuration macro: HZX_LINK_PARITY_EN.
module tb_zx_host_link;

  localparam int SYNC   = 2;
  localparam int SETUP  = 2;
  localparam int WIDTH  = 4;
  localparam int LWIDTH = 600;
  localparam int HALF   = 4;
`ifdef HZX_LINK_PARITY_EN
  localparam int FB = 17;
`else
  localparam int FB = 16;
`endif

  logic clk = 1'b0;
  logic rst_in, sck, mosi, cs_n;
  logic [7:0] di_d, di_l;
  logic mx_d, my_d, mkey_d, joy_d, busy_d, overrun_d, frame_err_d;
  logic mx_l, my_l, mkey_l, joy_l, busy_l, overrun_l, frame_err_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  zx_host_link u_dut (
    .clk(clk), .rst_in(rst_in), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .di(di_d), .mx(mx_d), .my(my_d), .mkey(mkey_d), .joy(joy_d),
    .busy(busy_d), .overrun(overrun_d), .frame_err(frame_err_d)
  );

  zx_host_link #(.STROBE_WIDTH(LWIDTH)) u_long (
    .clk(clk), .rst_in(rst_in), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .di(di_l), .mx(mx_l), .my(my_l), .mkey(mkey_l), .joy(joy_l),
    .busy(busy_l), .overrun(overrun_l), .frame_err(frame_err_l)
  );

  // ---------------- strobe monitor ----------------
  typedef struct {
    int         id;    // 1=mx 2=my 3=mkey 4=joy (same as the register address)
    logic [7:0] d;
    int         rise;
    int         fall;
  } ev_t;

  ev_t  ev_d[$];
  ev_t  ev_l[$];
  int   cyc = 0;
  int   multi_d = 0;
  int   multi_l = 0;
  logic [3:0] prev_d = 4'b0000;
  logic [3:0] prev_l = 4'b0000;

  always @(negedge clk) begin : mon
    logic [3:0] sd, sl;
    ev_t e;
    cyc = cyc + 1;
    sd = {joy_d, mkey_d, my_d, mx_d};
    sl = {joy_l, mkey_l, my_l, mx_l};
    if ($countones(sd) > 1) multi_d = multi_d + 1;
    if ($countones(sl) > 1) multi_l = multi_l + 1;
    for (int k = 0; k < 4; k++) begin
      if (sd[k] && !prev_d[k]) begin
        e.id = k + 1; e.d = di_d; e.rise = cyc; e.fall = -1; ev_d.push_back(e);
      end
      if (!sd[k] && prev_d[k] && ev_d.size() > 0) begin
        e = ev_d.pop_back(); e.fall = cyc; ev_d.push_back(e);
      end
      if (sl[k] && !prev_l[k]) begin
        e.id = k + 1; e.d = di_l; e.rise = cyc; e.fall = -1; ev_l.push_back(e);
      end
      if (!sl[k] && prev_l[k] && ev_l.size() > 0) begin
        e = ev_l.pop_back(); e.fall = cyc; ev_l.push_back(e);
      end
    end
    prev_d = sd;
    prev_l = sl;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] mk_frame(input logic [7:0] a, input logic [7:0] d);
`ifdef HZX_LINK_PARITY_EN
    return {47'd0, a, d, ~^{a, d}};
`else
    return {48'd0, a, d};
`endif
  endfunction

  // Sends n bits MSB first; returns right after cs_n rises on a falling clk edge.
  task automatic send_bits(input logic [63:0] b, input int n);
    $display("tb: frame %0d bits value=%h", n, b);
    @(negedge clk);
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = b[i];
      sck  = 1'b0;
      wait_clks(HALF);
      sck  = 1'b1;
      wait_clks(HALF);
    end
    sck = 1'b0;
    wait_clks(HALF);
    cs_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
    send_bits(mk_frame(a, d), FB);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b0;
    wait_clks(3);
    rst_in = 1'b1;
    wait_clks(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    wait_clks(3);
    n_checks++; if (di_d !== 8'hFF) begin n_fail++; $display("FAIL reset_di: got %h want ff", di_d); end
    n_checks++; if ({joy_d, mkey_d, my_d, mx_d} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {joy_d, mkey_d, my_d, mx_d}); end
    n_checks++; if ({busy_d, overrun_d, frame_err_d} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy_d, overrun_d, frame_err_d}); end
    n_checks++; if (di_l !== 8'hFF) begin n_fail++; $display("FAIL reset_di_long: got %h want ff", di_l); end
    rst_in = 1'b1;
    wait_clks(2);
  endtask

  task automatic test_timing();
    logic [7:0] di_s[12];
    logic       mx_s[12];
    logic       oth_s[12];
    logic       mx_exp;
    do_reset();
    send_frame(8'h01, 8'h85);
    // Sample k is one clk after the k-th rising edge following cs_n going high;
    // the synchronized rise is spec cycle 0 at sample SYNC-1.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      di_s[k] = di_d; mx_s[k] = mx_d; oth_s[k] = my_d | mkey_d | joy_d;
    end
    for (int k = 0; k < 12; k++) begin
      mx_exp = (k >= SYNC + SETUP) && (k < SYNC + SETUP + WIDTH);
      n_checks++; if (di_s[k] !== ((k >= SYNC) ? 8'h85 : 8'hFF)) begin n_fail++; $display("FAIL timing_di[%0d]: got %h want %h", k, di_s[k], (k >= SYNC) ? 8'h85 : 8'hFF); end
      n_checks++; if (mx_s[k] !== mx_exp) begin n_fail++; $display("FAIL timing_mx[%0d]: got %b want %b", k, mx_s[k], mx_exp); end
      n_checks++; if (oth_s[k] !== 1'b0) begin n_fail++; $display("FAIL timing_other[%0d]: got %b want 0", k, oth_s[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int bd, bl;
    do_reset();
    bd = ev_d.size(); bl = ev_l.size();
    send_frame(8'h02, 8'h10);
    wait_clks(10);
    send_frame(8'h03, 8'hFE);
    wait_clks(5);
    n_checks++; if (busy_l !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy_l); end
    wait_clks(2 * LWIDTH + 50);
    n_checks++; if (ev_l.size() - bl != 2) begin n_fail++; $display("FAIL b2b_count_long: got %0d want 2", ev_l.size() - bl); end
    else begin
      n_checks++; if (ev_l[bl].id != 2 || ev_l[bl].d !== 8'h10) begin n_fail++; $display("FAIL b2b_first: got id %0d di %h want id 2 di 10", ev_l[bl].id, ev_l[bl].d); end
      n_checks++; if (ev_l[bl+1].id != 3 || ev_l[bl+1].d !== 8'hFE) begin n_fail++; $display("FAIL b2b_second: got id %0d di %h want id 3 di fe", ev_l[bl+1].id, ev_l[bl+1].d); end
      n_checks++; if (ev_l[bl].fall - ev_l[bl].rise != LWIDTH) begin n_fail++; $display("FAIL b2b_width: got %0d want %0d", ev_l[bl].fall - ev_l[bl].rise, LWIDTH); end
      n_checks++; if (ev_l[bl+1].rise - ev_l[bl].fall < 1) begin n_fail++; $display("FAIL b2b_low_gap: got %0d want >=1", ev_l[bl+1].rise - ev_l[bl].fall); end
    end
    n_checks++; if (overrun_l !== 1'b0 || overrun_d !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b%b want 00", overrun_l, overrun_d); end
    n_checks++; if (busy_l !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b want 0", busy_l); end
    n_checks++; if (ev_d.size() - bd != 2) begin n_fail++; $display("FAIL b2b_count_dflt: got %0d want 2", ev_d.size() - bd); end
    n_checks++; if (multi_l != 0) begin n_fail++; $display("FAIL b2b_onehot: got %0d overlaps want 0", multi_l); end
  endtask

  task automatic test_overrun();
    int bd, bl;
    do_reset();
    bd = ev_d.size(); bl = ev_l.size();
    send_frame(8'h01, 8'hA1); wait_clks(10);
    send_frame(8'h02, 8'hA2); wait_clks(10);
    send_frame(8'h03, 8'hA3);
    wait_clks(2 * LWIDTH + 100);
    n_checks++; if (ev_l.size() - bl != 2) begin n_fail++; $display("FAIL ovr_count_long: got %0d want 2", ev_l.size() - bl); end
    else begin
      n_checks++; if (ev_l[bl].id != 1 || ev_l[bl].d !== 8'hA1) begin n_fail++; $display("FAIL ovr_first: got id %0d di %h want id 1 di a1", ev_l[bl].id, ev_l[bl].d); end
      n_checks++; if (ev_l[bl+1].id != 2 || ev_l[bl+1].d !== 8'hA2) begin n_fail++; $display("FAIL ovr_second: got id %0d di %h want id 2 di a2", ev_l[bl+1].id, ev_l[bl+1].d); end
    end
    n_checks++; if (overrun_l !== 1'b1) begin n_fail++; $display("FAIL ovr_flag_long: got %b want 1", overrun_l); end
    n_checks++; if (overrun_d !== 1'b0) begin n_fail++; $display("FAIL ovr_flag_dflt: got %b want 0", overrun_d); end
    n_checks++; if (ev_d.size() - bd != 3) begin n_fail++; $display("FAIL ovr_count_dflt: got %0d want 3", ev_d.size() - bd); end
    n_checks++; if (frame_err_l !== 1'b0) begin n_fail++; $display("FAIL ovr_frame_err: got %b want 0", frame_err_l); end
  endtask

  task automatic test_bad_length();
    int bd;
    do_reset();
    bd = ev_d.size();
    send_bits(64'hA5C, 12);
    wait_clks(20);
    n_checks++; if (frame_err_d !== 1'b1) begin n_fail++; $display("FAIL len12_err: got %b want 1", frame_err_d); end
    n_checks++; if (ev_d.size() != bd) begin n_fail++; $display("FAIL len12_strobe: got %0d pulses want 0", ev_d.size() - bd); end
    send_frame(8'h04, 8'h1F);
    wait_clks(20);
    n_checks++; if (ev_d.size() - bd != 1) begin n_fail++; $display("FAIL len12_next_count: got %0d want 1", ev_d.size() - bd); end
    else begin
      n_checks++; if (ev_d[bd].id != 4 || ev_d[bd].d !== 8'h1F) begin n_fail++; $display("FAIL len12_next_joy: got id %0d di %h want id 4 di 1f", ev_d[bd].id, ev_d[bd].d); end
    end
    n_checks++; if (frame_err_d !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", frame_err_d); end

    // 32 extra clocks: a wrapping counter would see a valid length here.
    do_reset();
    bd = ev_d.size();
    send_bits(mk_frame(8'h01, 8'h55) | (64'($urandom) << FB), FB + 32);
    wait_clks(20);
    n_checks++; if (frame_err_d !== 1'b1) begin n_fail++; $display("FAIL sat_err: got %b want 1", frame_err_d); end
    n_checks++; if (ev_d.size() != bd) begin n_fail++; $display("FAIL sat_strobe: got %0d pulses want 0", ev_d.size() - bd); end

    // One bit too many.
    do_reset();
    send_bits({mk_frame(8'h02, 8'h33), 1'b0}, FB + 1);
    wait_clks(20);
    n_checks++; if (frame_err_d !== 1'b1) begin n_fail++; $display("FAIL len_plus1_err: got %b want 1", frame_err_d); end

    // Select pulse with no clocks is ignored.
    do_reset();
    bd = ev_d.size();
    $display("tb: frame 0 bits (select pulse only)");
    @(negedge clk); cs_n = 1'b0;
    wait_clks(8);
    cs_n = 1'b1;
    wait_clks(20);
    n_checks++; if ({frame_err_d, overrun_d, busy_d} !== 3'b000) begin n_fail++; $display("FAIL zero_bits_flags: got %b want 000", {frame_err_d, overrun_d, busy_d}); end
    n_checks++; if (ev_d.size() != bd) begin n_fail++; $display("FAIL zero_bits_strobe: got %0d pulses want 0", ev_d.size() - bd); end
  endtask

  task automatic test_bad_addr();
    int bd;
    do_reset();
    bd = ev_d.size();
    send_frame(8'h07, 8'h3C);
    wait_clks(20);
    n_checks++; if (di_d !== 8'hFF) begin n_fail++; $display("FAIL addr7_di_reset: got %h want ff", di_d); end
    send_frame(8'h01, 8'h5A); wait_clks(20);
    send_frame(8'h07, 8'h3C); wait_clks(20);
    n_checks++; if (ev_d.size() - bd != 1) begin n_fail++; $display("FAIL addr7_count: got %0d want 1", ev_d.size() - bd); end
    n_checks++; if (di_d !== 8'h5A) begin n_fail++; $display("FAIL addr7_di_hold: got %h want 5a", di_d); end
    n_checks++; if ({frame_err_d, overrun_d} !== 2'b00) begin n_fail++; $display("FAIL addr7_flags: got %b want 00", {frame_err_d, overrun_d}); end
  endtask

  task automatic test_reset_mid();
    int bd;
    do_reset();
    send_frame(8'h01, 8'h99);
    wait_clks(SYNC + SETUP + 1);
    n_checks++; if (mx_d !== 1'b1) begin n_fail++; $display("FAIL rmid_in_strobe: got %b want 1", mx_d); end
    #2 rst_in = 1'b0;
    #1;
    n_checks++; if (mx_d !== 1'b0) begin n_fail++; $display("FAIL rmid_strobe_low: got %b want 0", mx_d); end
    n_checks++; if (di_d !== 8'hFF) begin n_fail++; $display("FAIL rmid_di: got %h want ff", di_d); end
    n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy_d); end
    wait_clks(2);
    rst_in = 1'b1;
    wait_clks(2);
    bd = ev_d.size();
    // Reset in the middle of shifting a frame.
    $display("tb: frame aborted by reset after 5 bits");
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1; sck = 1'b0; wait_clks(HALF);
      sck = 1'b1; wait_clks(HALF);
    end
    rst_in = 1'b0;
    wait_clks(3);
    sck = 1'b0; cs_n = 1'b1;
    wait_clks(2);
    rst_in = 1'b1;
    wait_clks(4);
    send_frame(8'h01, 8'h40);
    wait_clks(20);
    n_checks++; if (ev_d.size() - bd != 1) begin n_fail++; $display("FAIL rmid_next_count: got %0d want 1", ev_d.size() - bd); end
    else begin
      n_checks++; if (ev_d[bd].id != 1 || ev_d[bd].d !== 8'h40) begin n_fail++; $display("FAIL rmid_next: got id %0d di %h want id 1 di 40", ev_d[bd].id, ev_d[bd].d); end
    end
    n_checks++; if ({frame_err_d, overrun_d} !== 2'b00) begin n_fail++; $display("FAIL rmid_flags: got %b want 00", {frame_err_d, overrun_d}); end
`ifdef HZX_LINK_PARITY_EN
    bd = ev_d.size();
    send_bits(mk_frame(8'h01, 8'h77) ^ 64'd1, FB);
    wait_clks(20);
    n_checks++; if (frame_err_d !== 1'b1) begin n_fail++; $display("FAIL parity_err: got %b want 1", frame_err_d); end
    n_checks++; if (ev_d.size() != bd) begin n_fail++; $display("FAIL parity_strobe: got %0d pulses want 0", ev_d.size() - bd); end
`endif
  endtask

  task automatic test_random();
    int         bd, n, r;
    logic [7:0] a, d;
    logic [63:0] b;
    int         exp_id[$];
    logic [7:0] exp_d[$];
    logic       exp_err;
    logic [7:0] exp_di;
    do_reset();
    bd = ev_d.size();
    exp_err = 1'b0;
    exp_di  = 8'hFF;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      a = (r < 6) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(0, 255));
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(1, FB + 4);
        if (n == FB) n = FB + 1;
        b = {$urandom, $urandom};
        send_bits(b, n);
        exp_err = 1'b1;
      end else begin
        send_frame(a, d);
        if (a >= 8'd1 && a <= 8'd4) begin
          exp_id.push_back(int'(a));
          exp_d.push_back(d);
          exp_di = d;
        end
      end
      wait_clks(20);
    end
    n_checks++; if (ev_d.size() - bd != exp_id.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", ev_d.size() - bd, exp_id.size()); end
    else begin
      for (int i = 0; i < exp_id.size(); i++) begin
        n_checks++;
        if (ev_d[bd+i].id != exp_id[i] || ev_d[bd+i].d !== exp_d[i]) begin
          n_fail++; $display("FAIL rand_pulse[%0d]: got id %0d di %h want id %0d di %h", i, ev_d[bd+i].id, ev_d[bd+i].d, exp_id[i], exp_d[i]);
        end
      end
    end
    n_checks++; if (frame_err_d !== exp_err) begin n_fail++; $display("FAIL rand_frame_err: got %b want %b", frame_err_d, exp_err); end
    n_checks++; if (overrun_d !== 1'b0) begin n_fail++; $display("FAIL rand_overrun: got %b want 0", overrun_d); end
    n_checks++; if (di_d !== exp_di) begin n_fail++; $display("FAIL rand_di: got %h want %h", di_d, exp_di); end
    n_checks++; if (multi_d != 0) begin n_fail++; $display("FAIL rand_onehot: got %0d overlaps want 0", multi_d); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_back_to_back();
    test_overrun();
    test_bad_length();
    test_bad_addr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
